// File: rtl/gobang_pkg.sv
// Shared types for the gobang cursor controller: board geometry,
// FSM states, decoded actions and the history entry format.
package gobang_pkg;

   localparam int BOARD_SIZE_DEF = 15;
   localparam int CW = $clog2(BOARD_SIZE_DEF);

   typedef enum logic [1:0] {
      IDLE,
      PLACE,
      UNDO
   } state_t;

   typedef enum logic [3:0] {
      A_NONE,
      A_PLACE,
      A_PLACED,
      A_UNDO,
      A_UNDONE,
      A_SWITCH,
      A_REJECT,
      A_UP,
      A_DOWN,
      A_LEFT,
      A_RIGHT
   } act_t;

   typedef struct packed {
      logic [CW-1:0] row;
      logic [CW-1:0] col;
      logic          player;
   } move_t;

endpackage

// File: rtl/gobang_cursor_ctrl_if.sv
// Place/undo request channels between the cursor controller (master)
// and the board/game logic (slave).
interface gobang_cursor_ctrl_if #(
   parameter int CW = gobang_pkg::CW
);

   logic          place_valid;
   logic          place_ready;
   logic [CW-1:0] place_row;
   logic [CW-1:0] place_col;
   logic          place_player;

   logic          undo_valid;
   logic          undo_ready;
   logic [CW-1:0] undo_row;
   logic [CW-1:0] undo_col;

   modport master (
      output place_valid, place_row, place_col, place_player,
      output undo_valid, undo_row, undo_col,
      input  place_ready, undo_ready
   );

   modport slave (
      input  place_valid, place_row, place_col, place_player,
      input  undo_valid, undo_row, undo_col,
      output place_ready, undo_ready
   );

endinterface

// File: rtl/gobang_move_history.sv
// Circular LIFO of moves; top is read combinationally, push/pop are
// registered. A push when full overwrites the oldest entry.
module gobang_move_history
   import gobang_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int PW    = $clog2(DEPTH),
   localparam int NW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_slow,
   input  logic          rst,
   input  logic          push,
   input  move_t         push_data,
   input  logic          pop,
   output move_t         top,
   output logic [NW-1:0] count
);

   move_t         mem [DEPTH];
   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_inc;
   logic [PW-1:0] ptr_dec;
   logic          full;

   assign ptr_inc = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   assign ptr_dec = (ptr == '0) ? PW'(DEPTH - 1) : ptr - 1'b1;
   assign full    = (count == NW'(DEPTH));
   assign top     = mem[ptr_dec];

   always_ff @(posedge clk_slow) begin
      if (push)
         mem[ptr] <= push_data;
   end

   always_ff @(posedge clk_slow or negedge rst) begin
      if (!rst) begin
         ptr   <= '0;
         count <= '0;
      end else if (push) begin
         ptr <= ptr_inc;
         if (!full)
            count <= count + 1'b1;
      end else if (pop && count != '0) begin
         ptr   <= ptr_dec;
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/gobang_cursor_ctrl.sv
// Gobang cursor/turn controller: key pulses to place/undo requests.
// Define GOBANG_CURSOR_WRAP_EN to wrap the cursor at board edges.
module gobang_cursor_ctrl
   import gobang_pkg::*;
#(
   parameter  int BOARD_SIZE = BOARD_SIZE_DEF,
   parameter  int HIST_DEPTH = 8,
   localparam int HW         = $clog2(HIST_DEPTH + 1)
) (
   input  logic          clk_slow,
   input  logic          rst,
   input  logic          key_up,
   input  logic          key_down,
   input  logic          key_left,
   input  logic          key_right,
   input  logic          key_ok,
   input  logic          key_switch,
   input  logic          key_reverse,
   input  logic          cell_occupied,
   output logic [CW-1:0] cur_row,
   output logic [CW-1:0] cur_col,
   output logic          player,
   gobang_cursor_ctrl_if.master bus,
   output logic [HW-1:0] hist_count,
   output logic          busy,
   output logic          reject
);

   localparam logic [CW-1:0] MAXC = CW'(BOARD_SIZE - 1);
   localparam logic [CW-1:0] MIDC = CW'(BOARD_SIZE / 2);

   state_t        state, state_nxt;
   act_t          act;
   move_t         top_mv;
   move_t         push_mv;
   logic [CW-1:0] p_row, p_col, u_row, u_col;
   logic          p_player, u_player;

   function automatic logic [CW-1:0] step_dec(input logic [CW-1:0] v);
`ifdef GOBANG_CURSOR_WRAP_EN
      return (v == '0) ? MAXC : v - 1'b1;
`else
      return (v == '0) ? v : v - 1'b1;
`endif
   endfunction

   function automatic logic [CW-1:0] step_inc(input logic [CW-1:0] v);
`ifdef GOBANG_CURSOR_WRAP_EN
      return (v == MAXC) ? '0 : v + 1'b1;
`else
      return (v == MAXC) ? v : v + 1'b1;
`endif
   endfunction

   assign push_mv = '{p_row, p_col, p_player};

   gobang_move_history #(
      .DEPTH (HIST_DEPTH)
   ) u_hist (
      .clk_slow  (clk_slow),
      .rst       (rst),
      .push      (act == A_PLACED),
      .push_data (push_mv),
      .pop       (act == A_UNDO),
      .top       (top_mv),
      .count     (hist_count)
   );

   // Keys are strictly prioritised, so this is a priority chain.
   always_comb begin
      state_nxt = state;
      act       = A_NONE;
      unique case (state)
         IDLE: begin
            if (key_ok) begin
               if (cell_occupied) begin
                  act = A_REJECT;
               end else begin
                  act       = A_PLACE;
                  state_nxt = PLACE;
               end
            end else if (key_reverse) begin
               if (hist_count == '0) begin
                  act = A_REJECT;
               end else begin
                  act       = A_UNDO;
                  state_nxt = UNDO;
               end
            end else if (key_switch) begin
               act = (hist_count == '0) ? A_SWITCH : A_REJECT;
            end else if (key_up) begin
               act = A_UP;
            end else if (key_down) begin
               act = A_DOWN;
            end else if (key_left) begin
               act = A_LEFT;
            end else if (key_right) begin
               act = A_RIGHT;
            end
         end
         PLACE: begin
            if (bus.place_ready) begin
               act       = A_PLACED;
               state_nxt = IDLE;
            end
         end
         UNDO: begin
            if (bus.undo_ready) begin
               act       = A_UNDONE;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_slow or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cur_row  <= MIDC;
         cur_col  <= MIDC;
         player   <= 1'b0;
         p_row    <= '0;
         p_col    <= '0;
         p_player <= 1'b0;
         u_row    <= '0;
         u_col    <= '0;
         u_player <= 1'b0;
         reject   <= 1'b0;
      end else begin
         state  <= state_nxt;
         reject <= (act == A_REJECT);
         unique case (act)
            A_PLACE: begin
               p_row    <= cur_row;
               p_col    <= cur_col;
               p_player <= player;
            end
            A_PLACED: player <= ~player;
            A_UNDO: begin
               u_row    <= top_mv.row;
               u_col    <= top_mv.col;
               u_player <= top_mv.player;
            end
            A_UNDONE: begin
               player  <= u_player;
               cur_row <= u_row;
               cur_col <= u_col;
            end
            A_SWITCH: player  <= ~player;
            A_UP:     cur_row <= step_dec(cur_row);
            A_DOWN:   cur_row <= step_inc(cur_row);
            A_LEFT:   cur_col <= step_dec(cur_col);
            A_RIGHT:  cur_col <= step_inc(cur_col);
            default: ;
         endcase
      end
   end

   assign busy             = (state != IDLE);
   assign bus.place_valid  = (state == PLACE);
   assign bus.place_row    = p_row;
   assign bus.place_col    = p_col;
   assign bus.place_player = p_player;
   assign bus.undo_valid   = (state == UNDO);
   assign bus.undo_row     = u_row;
   assign bus.undo_col     = u_col;

endmodule

// File: tb/tb_gobang_cursor_ctrl.sv
// Scoreboard bench for gobang_cursor_ctrl (HIST_DEPTH=4); expected
// edge behaviour follows GOBANG_CURSOR_WRAP_EN.
module tb_gobang_cursor_ctrl;

   localparam int K_OK = 0;
   localparam int K_RV = 1;
   localparam int K_SW = 2;
   localparam int K_UP = 3;
   localparam int K_DN = 4;
   localparam int K_LT = 5;
   localparam int K_RT = 6;

   localparam int E_PLACE = 0;
   localparam int E_UNDO  = 1;
   localparam int E_REJ   = 2;

   typedef struct {
      int kind;
      int row;
      int col;
      int ply;
   } ev_t;

   logic       clk_slow = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] keys = '0;
   logic       cell_occupied = 1'b0;
   logic [3:0] cur_row, cur_col;
   logic       player, busy, reject;
   logic [2:0] hist_count;

   ev_t sb[$];
   ev_t got;
   int  passed = 0;
   int  total = 0;

   gobang_cursor_ctrl_if bus ();

   gobang_cursor_ctrl #(
      .BOARD_SIZE (15),
      .HIST_DEPTH (4)
   ) dut (
      .clk_slow      (clk_slow),
      .rst           (rst),
      .key_up        (keys[K_UP]),
      .key_down      (keys[K_DN]),
      .key_left      (keys[K_LT]),
      .key_right     (keys[K_RT]),
      .key_ok        (keys[K_OK]),
      .key_switch    (keys[K_SW]),
      .key_reverse   (keys[K_RV]),
      .cell_occupied (cell_occupied),
      .cur_row       (cur_row),
      .cur_col       (cur_col),
      .player        (player),
      .bus           (bus),
      .hist_count    (hist_count),
      .busy          (busy),
      .reject        (reject)
   );

   always #5 clk_slow = ~clk_slow;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp)
         passed++;
      else
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic unexpected(input string name);
      total++;
      $display("FAIL %s: got event expected none", name);
   endtask

   task automatic tick;
      @(posedge clk_slow);
      #1;
   endtask

   task automatic press(input int k);
      keys    = '0;
      keys[k] = 1'b1;
      tick();
      keys = '0;
   endtask

   task automatic expect_ev(input int kind, input int r, input int c,
                            input int p);
      ev_t e;
      e.kind = kind;
      e.row  = r;
      e.col  = c;
      e.ply  = p;
      sb.push_back(e);
   endtask

   // Monitor: each handshake or reject cycle consumes one expectation.
   always @(negedge clk_slow) begin
      if (rst) begin
         if (bus.place_valid && bus.place_ready) begin
            if (sb.size() == 0) begin
               unexpected("place_evt");
            end else begin
               got = sb.pop_front();
               chk("place_kind", E_PLACE, got.kind);
               chk("place_row", int'(bus.place_row), got.row);
               chk("place_col", int'(bus.place_col), got.col);
               chk("place_ply", int'(bus.place_player), got.ply);
            end
         end
         if (bus.undo_valid && bus.undo_ready) begin
            if (sb.size() == 0) begin
               unexpected("undo_evt");
            end else begin
               got = sb.pop_front();
               chk("undo_kind", E_UNDO, got.kind);
               chk("undo_row", int'(bus.undo_row), got.row);
               chk("undo_col", int'(bus.undo_col), got.col);
            end
         end
         if (reject) begin
            if (sb.size() == 0) begin
               unexpected("reject_evt");
            end else begin
               got = sb.pop_front();
               chk("reject_kind", E_REJ, got.kind);
            end
         end
      end
   end

   int u_r[3] = '{7, 7, 7};
   int u_c[3] = '{9, 8, 7};
   int u_p[3] = '{1, 0, 1};
   int u_h[3] = '{2, 1, 0};

   initial begin
      bus.place_ready = 1'b1;
      bus.undo_ready  = 1'b1;
      #6;
      chk("rst_row", int'(cur_row), 7);
      chk("rst_col", int'(cur_col), 7);
      chk("rst_player", int'(player), 0);
      chk("rst_hist", int'(hist_count), 0);
      chk("rst_pvalid", int'(bus.place_valid), 0);
      chk("rst_uvalid", int'(bus.undo_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_reject", int'(reject), 0);
      chk("rst_prow", int'(bus.place_row), 0);
      @(negedge clk_slow);
      rst = 1'b1;
      tick();

      repeat (7) press(K_UP);
      chk("row_top", int'(cur_row), 0);
      press(K_UP);
`ifdef GOBANG_CURSOR_WRAP_EN
      chk("row_wrap_up", int'(cur_row), 14);
      press(K_DN);
      chk("row_wrap_dn", int'(cur_row), 0);
`else
      chk("row_sat_up", int'(cur_row), 0);
`endif
      repeat (7) press(K_DN);
      chk("row_back", int'(cur_row), 7);
      repeat (7) press(K_RT);
      chk("col_right", int'(cur_col), 14);
      press(K_RT);
`ifdef GOBANG_CURSOR_WRAP_EN
      chk("col_wrap_rt", int'(cur_col), 0);
      press(K_LT);
`else
      chk("col_sat_rt", int'(cur_col), 14);
`endif
      repeat (7) press(K_LT);
      chk("col_back", int'(cur_col), 7);

      // Place held while ready is low; key_up inside PLACE is dropped.
      bus.place_ready = 1'b0;
      expect_ev(E_PLACE, 7, 7, 0);
      press(K_OK);
      for (int i = 0; i < 3; i++) begin
         chk("hold_valid", int'(bus.place_valid), 1);
         chk("hold_row", int'(bus.place_row), 7);
         chk("hold_busy", int'(busy), 1);
         keys[K_UP] = (i == 1);
         tick();
         keys = '0;
      end
      bus.place_ready = 1'b1;
      tick();
      chk("m1_valid", int'(bus.place_valid), 0);
      chk("m1_player", int'(player), 1);
      chk("m1_hist", int'(hist_count), 1);
      chk("m1_row", int'(cur_row), 7);

      cell_occupied = 1'b1;
      expect_ev(E_REJ, 0, 0, 0);
      press(K_OK);
      cell_occupied = 1'b0;
      chk("occ_valid", int'(bus.place_valid), 0);
      chk("occ_player", int'(player), 1);
      tick();

      expect_ev(E_PLACE, 7, 7, 1);
      keys[K_OK] = 1'b1;
      keys[K_RT] = 1'b1;
      tick();
      keys = '0;
      chk("okrt_col", int'(cur_col), 7);
      tick();
      chk("m2_player", int'(player), 0);
      chk("m2_hist", int'(hist_count), 2);

      press(K_RT);
      expect_ev(E_PLACE, 7, 8, 0);
      press(K_OK);
      tick();
      press(K_RT);
      expect_ev(E_PLACE, 7, 9, 1);
      press(K_OK);
      tick();
      chk("m4_hist", int'(hist_count), 4);
      press(K_DN);
      expect_ev(E_PLACE, 8, 9, 0);
      press(K_OK);
      tick();
      chk("m5_hist", int'(hist_count), 4);
      chk("m5_player", int'(player), 1);

      expect_ev(E_REJ, 0, 0, 0);
      press(K_SW);
      chk("sw_busy_player", int'(player), 1);
      tick();

      bus.undo_ready = 1'b0;
      expect_ev(E_UNDO, 8, 9, 0);
      press(K_RV);
      chk("u1_valid", int'(bus.undo_valid), 1);
      chk("u1_row", int'(bus.undo_row), 8);
      chk("u1_col", int'(bus.undo_col), 9);
      chk("u1_hist", int'(hist_count), 3);
      tick();
      tick();
      chk("u1_hold_row", int'(bus.undo_row), 8);
      bus.undo_ready = 1'b1;
      tick();
      chk("u1_done", int'(bus.undo_valid), 0);
      chk("u1_player", int'(player), 0);
      chk("u1_cur_row", int'(cur_row), 8);
      chk("u1_cur_col", int'(cur_col), 9);

      for (int i = 0; i < 3; i++) begin
         expect_ev(E_UNDO, u_r[i], u_c[i], u_p[i]);
         press(K_RV);
         tick();
         chk("un_player", int'(player), u_p[i]);
         chk("un_row", int'(cur_row), u_r[i]);
         chk("un_col", int'(cur_col), u_c[i]);
         chk("un_hist", int'(hist_count), u_h[i]);
      end

      expect_ev(E_REJ, 0, 0, 0);
      press(K_RV);
      chk("empty_uvalid", int'(bus.undo_valid), 0);
      tick();
      press(K_SW);
      chk("sw_player", int'(player), 0);
      tick();

      // Reset during a pending place discards it immediately.
      bus.place_ready = 1'b0;
      press(K_OK);
      chk("pre_rst_valid", int'(bus.place_valid), 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", int'(bus.place_valid), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_hist", int'(hist_count), 0);
      bus.place_ready = 1'b1;
      @(negedge clk_slow);
      rst = 1'b1;
      tick();
      tick();
      chk("post_rst_valid", int'(bus.place_valid), 0);
      chk("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/gobang_cursor_ctrl.md
# gobang_cursor_ctrl

Consumes the single-cycle key pulses produced by the PS2 keyboard front end and turns them into game actions on the gobang board. It keeps the cursor position and the current player, and issues place and undo requests to the board/game logic over valid/ready handshakes. It also keeps a bounded move history so that the reverse key can undo moves. It sits directly downstream of the keyboard input stage and runs in the same clk_slow domain.

## Interface
Parameters:
- BOARD_SIZE, 15, board side length; coordinates run 0..BOARD_SIZE-1
- HIST_DEPTH, 8, number of moves kept for undo (≥2)

Ports:
- clk_slow  in  1  system slow clock; all state changes on rising edge
- rst  in  1  reset: asynchronous, active-low
- key_up, key_down, key_left, key_right, key_ok, key_switch, key_reverse  in  1 each  one-cycle key pulses
- cell_occupied  in  1  board status at (cur_row, cur_col); combinational from the board
- cur_row, cur_col  out  CW=$clog2(BOARD_SIZE)  cursor position
- player  out  1  side to move (0 black, 1 white)
- place_valid  out  1  place request; held until accepted
- place_ready  in  1  board accepts the place request
- place_row, place_col  out  CW  coordinate of the place request
- place_player  out  1  player for the place request
- undo_valid  out  1  undo request; held until accepted
- undo_ready  in  1  board accepts the undo request
- undo_row, undo_col  out  CW  cell to clear
- hist_count  out  $clog2(HIST_DEPTH+1)  number of undoable moves
- busy  out  1  high whenever the FSM is not in IDLE
- reject  out  1  one-cycle pulse when an action is refused

## Operation
FSM states and behaviour:
- IDLE: accepts key pulses.
- PLACE: place_valid=1 until place_valid&place_ready.
- UNDO: undo_valid=1 until undo_valid&undo_ready.

Key priority in IDLE: only one event is handled per cycle, in this order: ok > reverse > switch > up > down > left > right. All other pulses in that cycle are discarded. Any pulse that arrives outside IDLE is discarded.

Cursor movement:
- up decrements cur_row; down increments cur_row.
- left decrements cur_col; right increments cur_col.
- Edge behaviour is set by the macro described under Configuration.

ok:
- If cell_occupied=1: pulse reject and stay in IDLE.
- Otherwise: latch cursor and player into place_row/col/player and go to PLACE.
- On the handshake: push the move onto the history, toggle player, return to IDLE.

reverse:
- If hist_count=0: pulse reject.
- Otherwise: pop the top entry, drive it on undo_row/col, go to UNDO.
- On the handshake: player is set to the popped player, the cursor moves to the undone cell, return to IDLE.

switch:
- Toggles player only when hist_count=0.
- Otherwise pulse reject.

History:
- Implemented as a circular LIFO.
- A push when full overwrites the oldest entry; hist_count saturates at HIST_DEPTH.

Reset:
- Values: cursor at (BOARD_SIZE/2, BOARD_SIZE/2), i.e. (7,7) by default; player=0; all valid/reject/busy outputs 0; hist_count=0; place/undo coordinate outputs 0; FSM in IDLE.
- If reset asserts mid-handshake, valid drops immediately and the pending request is discarded.

## Timing
- Key pulse sampled at edge N; cursor, place_valid or undo_valid update at edge N (visible in cycle N+1). reject is high in cycle N+1 only.
- Handshake completes at the edge where valid&ready=1. valid is low in the following cycle and the next key is accepted from that cycle.
- Minimum request spacing is 2 cycles.
- Payload stays stable while valid=1. valid never drops without ready.
- cell_occupied must be valid in the same cycle as the ok pulse.

## Configuration
- GOBANG_CURSOR_WRAP_EN defined: moving off an edge wraps to the opposite edge (row 0 + up → BOARD_SIZE-1; BOARD_SIZE-1 + right → 0).
- Not defined: the cursor saturates at the edges and the key has no effect (no reject pulse).

## Structure
- gobang_pkg holds:
  - the BOARD_SIZE default and the CW constant
  - the FSM state enum (IDLE, PLACE, UNDO)
  - a move_t struct {row, col, player}
- Sub-module gobang_move_history: parameterised circular LIFO of move_t with push, pop, top, count and full. Pop of the top entry is combinational; the update is registered.

## Test plan
- Reset released → cur=(7,7), player=0, hist_count=0, place_valid=undo_valid=reject=busy=0.
- cur_row=0, key_up → cur_row=14 with GOBANG_CURSOR_WRAP_EN, cur_row=0 without it.
- key_ok at empty (7,7), place_ready low for 3 cycles → place_valid held with (7,7,0). Then ready=1 → next cycle valid=0, player=1, hist_count=1.
- key_ok with cell_occupied=1 → reject high for one cycle, no place_valid, player unchanged.
- HIST_DEPTH=4: place 5 moves then press reverse 5 times → undo requests for moves 5,4,3,2, then a reject pulse. hist_count goes 4→0.
- key_ok and key_right in the same cycle → place only, cursor unchanged. key_up while in PLACE → ignored, cur_row unchanged after the handshake.
